// File: rtl/masked_xor_pipe_pkg.sv
// Shared types and constants for the masked XOR/XNOR pipeline.
package masked_xor_pipe_pkg;

  localparam int unsigned ShareWidth = 8;

  typedef bit [ShareWidth-1:0] share_word_t;

  localparam logic OP_XOR  = 1'b0;
  localparam logic OP_XNOR = 1'b1;

endpackage

// File: rtl/masked_xor_pipe_if.sv
// Handshaked operand/result bundle for masked_xor_pipe.
interface masked_xor_pipe_if #(
  parameter int unsigned NUM_SHARES = 2,
  parameter int unsigned WIDTH      = 8
);

  logic [NUM_SHARES*WIDTH-1:0]     in_a;
  logic [NUM_SHARES*WIDTH-1:0]     in_b;
  logic                            in_op;
  logic [(NUM_SHARES-1)*WIDTH-1:0] in_r;
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_SHARES*WIDTH-1:0]     out_c;
  logic                            out_valid;
  logic                            out_ready;

  modport master (
    output in_a, in_b, in_op, in_r, in_valid, out_ready,
    input  in_ready, out_c, out_valid
  );

  modport slave (
    input  in_a, in_b, in_op, in_r, in_valid, out_ready,
    output in_ready, out_c, out_valid
  );

endinterface

// File: rtl/masked_refresh.sv
// Combinational share refresh: shares 0..N-2 absorb one fresh word each, the last share
// absorbs their XOR so the unmasked value is preserved.
module masked_refresh
  import masked_xor_pipe_pkg::*;
#(
  parameter int unsigned NUM_SHARES = 2,
  parameter int unsigned WIDTH      = 8
) (
  input  logic [NUM_SHARES*WIDTH-1:0]     c_in,
  input  logic [(NUM_SHARES-1)*WIDTH-1:0] r,
  output logic [NUM_SHARES*WIDTH-1:0]     c_out
);

  logic [WIDTH-1:0] r_sum;

  always_comb begin
    c_out = c_in;
    r_sum = '0;
    for (int unsigned i = 0; i < NUM_SHARES - 1; i++) begin
      c_out[i*WIDTH +: WIDTH] = c_in[i*WIDTH +: WIDTH] ^ r[i*WIDTH +: WIDTH];
      r_sum                   = r_sum ^ r[i*WIDTH +: WIDTH];
    end
    c_out[(NUM_SHARES-1)*WIDTH +: WIDTH] = c_in[(NUM_SHARES-1)*WIDTH +: WIDTH] ^ r_sum;
  end

endmodule

// File: rtl/register.sv
// Generic enabled register with asynchronous active-low reset.
module register #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/masked_xor_pipe.sv
// Elastic, registered masked XOR/XNOR with optional refresh in the first stage.
module masked_xor_pipe
  import masked_xor_pipe_pkg::*;
#(
  parameter int unsigned NUM_SHARES = 2,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned STAGES     = 1,
  parameter int unsigned REFRESH    = 1
) (
  input logic              clk_i,
  input logic              rst_ni,
  masked_xor_pipe_if.slave bus
);

  localparam int unsigned DataWidth = NUM_SHARES * WIDTH;

  logic [DataWidth-1:0]             xor_c;
  logic [DataWidth-1:0]             stage0_d;
  logic [STAGES-1:0]                valid_q;
  logic [STAGES-1:0]                load;
  logic [STAGES-1:0][DataWidth-1:0] data_q;
  logic                             adv;

  // Only share 0 carries the inversion, so the complement is applied exactly once.
  always_comb begin
    xor_c = bus.in_a ^ bus.in_b;
    if (bus.in_op == OP_XNOR) begin
      xor_c[WIDTH-1:0] = ~xor_c[WIDTH-1:0];
    end
  end

  if (REFRESH != 0) begin : g_refresh
    masked_refresh #(
      .NUM_SHARES(NUM_SHARES),
      .WIDTH     (WIDTH)
    ) u_refresh (
      .c_in (xor_c),
      .r    (bus.in_r),
      .c_out(stage0_d)
    );
  end else begin : g_no_refresh
    assign stage0_d = xor_c;
  end

  // Ready ripples backwards from out_ready: a stage loads when empty or when draining.
  always_comb begin
    load = '0;
    adv  = bus.out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      load[k] = ~valid_q[k] | adv;
      adv     = load[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                 prev_valid;
    logic [DataWidth-1:0] prev_data;

    if (k == 0) begin : g_first
      assign prev_valid = bus.in_valid;
      assign prev_data  = stage0_d;
    end else begin : g_rest
      assign prev_valid = valid_q[k-1];
      assign prev_data  = data_q[k-1];
    end

    register #(
      .WIDTH      (1),
      .RESET_VALUE(1'b0)
    ) u_valid (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .en    (load[k]),
      .d     (prev_valid),
      .q     (valid_q[k])
    );

    // Data only moves with a real beat, so bubbles never disturb held shares.
    register #(
      .WIDTH      (DataWidth),
      .RESET_VALUE('0)
    ) u_data (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .en    (load[k] & prev_valid),
      .d     (prev_data),
      .q     (data_q[k])
    );
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_c     = data_q[STAGES-1];

endmodule

// File: tb/tb_masked_xor_pipe.sv
// Scoreboard bench: a 3-stage unrefreshed 2-share pipe and a 1-stage refreshed 3-share pipe.
module tb_masked_xor_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  masked_xor_pipe_if #(.NUM_SHARES(2), .WIDTH(8)) ia ();
  masked_xor_pipe_if #(.NUM_SHARES(3), .WIDTH(8)) ib ();

  masked_xor_pipe #(
    .NUM_SHARES(2),
    .WIDTH     (8),
    .STAGES    (3),
    .REFRESH   (0)
  ) u_dut_a (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (ia)
  );

  masked_xor_pipe #(
    .NUM_SHARES(3),
    .WIDTH     (8),
    .STAGES    (1),
    .REFRESH   (1)
  ) u_dut_b (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (ib)
  );

  logic [15:0] qa[$];
  logic [23:0] qb[$];
  logic [15:0] a_exp = '0;
  logic [23:0] b_exp = '0;
  logic        a_hold = 1'b0;
  logic [15:0] a_hold_c = '0;
  logic        b_hold = 1'b0;
  logic [23:0] b_hold_c = '0;
  int          a_run = 0;
  int          a_last_run = 0;
  logic        b_rand_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_a(input logic [15:0] a, input logic [15:0] b,
                                          input logic op);
    logic [15:0] c;
    c = a ^ b;
    if (op) c[7:0] = ~c[7:0];
    return c;
  endfunction

  function automatic logic [23:0] model_b(input logic [23:0] a, input logic [23:0] b,
                                          input logic op, input logic [15:0] r);
    logic [23:0] c;
    c = a ^ b;
    if (op) c[7:0] = ~c[7:0];
    c[7:0]   = c[7:0] ^ r[7:0];
    c[15:8]  = c[15:8] ^ r[15:8];
    c[23:16] = c[23:16] ^ r[7:0] ^ r[15:8];
    return c;
  endfunction

  // Monitors: sample mid-cycle; a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      a_hold = 1'b0;
      a_run  = 0;
    end else begin
      if (a_hold) begin
        check("a_stall_valid", 32'(ia.out_valid), 32'd1);
        check("a_stall_data", 32'(ia.out_c), 32'(a_hold_c));
      end
      if (ia.out_valid && ia.out_ready) begin
        check("a_out_expected", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) check("a_out_data", 32'(ia.out_c), 32'(qa.pop_front()));
      end
      if (ia.in_valid && ia.in_ready) qa.push_back(a_exp);
      a_hold   = ia.out_valid && !ia.out_ready;
      a_hold_c = ia.out_c;
      if (ia.out_valid) begin
        a_run++;
      end else begin
        if (a_run != 0) a_last_run = a_run;
        a_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      qb.delete();
      b_hold = 1'b0;
    end else begin
      if (b_hold) begin
        check("b_stall_valid", 32'(ib.out_valid), 32'd1);
        check("b_stall_data", 32'(ib.out_c), 32'(b_hold_c));
      end
      if (ib.out_valid && ib.out_ready) begin
        check("b_out_expected", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) check("b_out_data", 32'(ib.out_c), 32'(qb.pop_front()));
      end
      if (ib.in_valid && ib.in_ready) qb.push_back(b_exp);
      b_hold   = ib.out_valid && !ib.out_ready;
      b_hold_c = ib.out_c;
    end
  end

  task automatic a_send(input logic [15:0] a, input logic [15:0] b, input logic op,
                        input logic [15:0] exp);
    bit ok;
    ok          = 1'b0;
    ia.in_a     = a;
    ia.in_b     = b;
    ia.in_op    = op;
    ia.in_r     = 8'($urandom);
    ia.in_valid = 1'b1;
    a_exp       = exp;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ia.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("a_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic a_send_rand();
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    a  = 16'($urandom);
    b  = 16'($urandom);
    op = 1'($urandom_range(0, 1));
    a_send(a, b, op, model_a(a, b, op));
  endtask

  task automatic b_send(input logic [23:0] a, input logic [23:0] b, input logic op,
                        input logic [15:0] r, input logic [23:0] exp);
    bit ok;
    ok          = 1'b0;
    ib.in_a     = a;
    ib.in_b     = b;
    ib.in_op    = op;
    ib.in_r     = r;
    ib.in_valid = 1'b1;
    b_exp       = exp;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ib.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("b_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic b_send_rand();
    logic [23:0] a;
    logic [23:0] b;
    logic        op;
    logic [15:0] r;
    a  = 24'($urandom);
    b  = 24'($urandom);
    op = 1'($urandom_range(0, 1));
    r  = 16'($urandom);
    b_send(a, b, op, r, model_b(a, b, op, r));
  endtask

  task automatic measure_latency(input string tag, input bit use_b, input int exp);
    int lat;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (use_b ? ib.out_valid : ia.out_valid) begin
        lat = i;
        break;
      end
    end
    check(tag, 32'(lat), 32'(exp));
  endtask

  initial begin
    int acc;
    ia.in_a = '0; ia.in_b = '0; ia.in_op = 1'b0; ia.in_r = '0;
    ia.in_valid = 1'b0; ia.out_ready = 1'b1;
    ib.in_a = '0; ib.in_b = '0; ib.in_op = 1'b0; ib.in_r = '0;
    ib.in_valid = 1'b0; ib.out_ready = 1'b1;

    #1 rst_n = 1'b0;
    #2;
    check("rst_a_valid", 32'(ia.out_valid), 32'd0);
    check("rst_a_data", 32'(ia.out_c), 32'd0);
    check("rst_a_ready", 32'(ia.in_ready), 32'd1);
    check("rst_b_valid", 32'(ib.out_valid), 32'd0);
    check("rst_b_data", 32'(ib.out_c), 32'd0);
    check("rst_b_ready", 32'(ib.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("post_rst_a_ready", 32'(ia.in_ready), 32'd1);
    check("post_rst_a_valid", 32'(ia.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Directed XOR / XNOR vectors through the 3-stage pipe.
    a_send(16'h5A3C, 16'hF00F, 1'b0, 16'hAA33);
    ia.in_valid = 1'b0;
    measure_latency("a_latency", 1'b0, 3);
    repeat (3) @(posedge clk);
    #1;
    a_send(16'h5A3C, 16'hF00F, 1'b1, 16'hAACC);
    ia.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Ten back-to-back beats at full throughput.
    repeat (10) a_send_rand();
    ia.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("a_b2b_run", 32'(a_last_run), 32'd10);
    check("a_b2b_drained", 32'(qa.size()), 32'd0);
    @(posedge clk);
    #1;

    // Backpressure: only STAGES beats fit while out_ready is low.
    ia.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      ia.in_a     = 16'($urandom);
      ia.in_b     = 16'($urandom);
      ia.in_op    = 1'($urandom_range(0, 1));
      ia.in_valid = 1'b1;
      a_exp       = model_a(ia.in_a, ia.in_b, ia.in_op);
      @(negedge clk);
      if (ia.in_ready) acc++;
      @(posedge clk);
      #1;
    end
    ia.in_valid = 1'b0;
    @(negedge clk);
    check("a_stall_accepts", 32'(acc), 32'd3);
    check("a_full_in_ready", 32'(ia.in_ready), 32'd0);
    check("a_full_out_valid", 32'(ia.out_valid), 32'd1);
    @(posedge clk);
    #1;
    ia.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("a_stall_drained", 32'(qa.size()), 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset with two beats in flight.
    ia.out_ready = 1'b0;
    a_send_rand();
    a_send_rand();
    ia.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("a_pre_rst_valid", 32'(ia.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("a_async_rst_valid", 32'(ia.out_valid), 32'd0);
    check("a_async_rst_data", 32'(ia.out_c), 32'd0);
    check("a_async_rst_ready", 32'(ia.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ia.out_ready = 1'b1;
    #1;
    check("a_rel_ready", 32'(ia.in_ready), 32'd1);
    repeat (8) @(negedge clk);
    check("a_rel_quiet", 32'(ia.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Refreshed 3-share pipe: directed vectors, then random beats under random backpressure.
    b_send(24'h0000FF, 24'h000000, 1'b0, 16'h2211, 24'h3322EE);
    ib.in_valid = 1'b0;
    measure_latency("b_latency", 1'b1, 1);
    @(posedge clk);
    #1;
    b_send(24'h0000FF, 24'h000000, 1'b1, 16'h2211, 24'h332211);
    ib.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    b_rand_on = 1'b1;
    fork
      begin
        repeat (12) b_send_rand();
        ib.in_valid = 1'b0;
        b_rand_on   = 1'b0;
      end
      begin
        while (b_rand_on) begin
          @(posedge clk);
          #1;
          ib.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    ib.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("b_drained", 32'(qb.size()), 32'd0);
    check("b_idle_valid", 32'(ib.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
